// File: rtl/mpu_i2c_engine.sv
// Bus-side I2C master for the MPU6050: START, address, n write bytes, optional
// repeated-START read of m bytes, STOP. Each bit is four CLK_DIV-clock quarters.
module mpu_i2c_engine #(
  parameter int unsigned CLK_DIV  = 250,
  parameter logic [6:0]  DEV_ADDR = 7'h68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_start,
  input  logic         rd_now,
  input  logic [15:0]  n,
  input  logic [15:0]  m,
  input  logic [127:0] data_packed,
  input  logic         sda_i,
  output logic         scl_oe,
  output logic         sda_oe,
  output logic         busy,
  output logic         done,
  output logic         ack_err,
  output logic [127:0] rd_data
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RSTART, RD_BYTE, RD_ACK, STOP
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [1:0]     qtr_q, qtr_d;
  logic [2:0]     bit_q, bit_d;
  logic [4:0]     byte_q, byte_d;
  logic [4:0]     n_q, n_d;
  logic [4:0]     m_q, m_d;
  logic           rd_q, rd_d;
  logic           rw_q, rw_d;
  logic           smp_q, smp_d;
  logic [7:0]     sh_q, sh_d;
  logic [127:0]   wbuf_q, wbuf_d;
  logic [127:0]   rdat_q, rdat_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           q_end, bit_end, smp_pt, rd_ack_drive;
  logic [4:0]     n_clamp, m_clamp;

  assign q_end        = (div_q == DW'(CLK_DIV - 1));
  assign bit_end      = q_end && (qtr_q == 2'd3);
  assign smp_pt       = q_end && (qtr_q == 2'd1);
  assign rd_ack_drive = (byte_q + 5'd1) < m_q;

  assign n_clamp = (n > 16'd16) ? 5'd16 : n[4:0];
  assign m_clamp = (m == 16'd0) ? 5'd1 : ((m > 16'd16) ? 5'd16 : m[4:0]);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    n_d     = n_q;
    m_d     = m_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    smp_d   = smp_q;
    sh_d    = sh_q;
    wbuf_d  = wbuf_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      div_d = '0;
      qtr_d = '0;
      if (en_start) begin
        state_d = START;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        rdat_d  = '0;
        rd_d    = rd_now;
        n_d     = n_clamp;
        m_d     = m_clamp;
        wbuf_d  = data_packed;
        bit_d   = '0;
        byte_d  = '0;
      end
    end else begin
      if (q_end) begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + DW'(1);
      end

      if (smp_pt) begin
        smp_d = sda_i;
        if (state_q == RD_BYTE) sh_d = {sh_q[6:0], sda_i};
      end

      if (bit_end) begin
        unique case (state_q)
          START: begin
            state_d = ADDR;
            rw_d    = rd_q && (n_q == 5'd0);
            sh_d    = {DEV_ADDR, rd_q && (n_q == 5'd0)};
            bit_d   = '0;
          end
          ADDR, WR_BYTE: begin
            if (bit_q == 3'd7) begin
              state_d = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
          ADDR_ACK: begin
            if (smp_q) begin
              err_d   = 1'b1;
              state_d = STOP;
            end else if (rw_q) begin
              state_d = RD_BYTE;
              bit_d   = '0;
              byte_d  = '0;
            end else if (n_q == 5'd0) begin
              state_d = STOP;
            end else begin
              state_d = WR_BYTE;
              sh_d    = wbuf_q[127:120];
              wbuf_d  = {wbuf_q[119:0], 8'h00};
              bit_d   = '0;
              byte_d  = '0;
            end
          end
          WR_ACK: begin
            if (smp_q) begin
              err_d   = 1'b1;
              state_d = STOP;
            end else if ((byte_q + 5'd1) < n_q) begin
              state_d = WR_BYTE;
              sh_d    = wbuf_q[127:120];
              wbuf_d  = {wbuf_q[119:0], 8'h00};
              bit_d   = '0;
              byte_d  = byte_q + 5'd1;
            end else begin
              state_d = rd_q ? RSTART : STOP;
            end
          end
          RSTART: begin
            state_d = ADDR;
            rw_d    = 1'b1;
            sh_d    = {DEV_ADDR, 1'b1};
            bit_d   = '0;
          end
          RD_BYTE: begin
            if (bit_q == 3'd7) state_d = RD_ACK;
            else               bit_d   = bit_q + 3'd1;
          end
          RD_ACK: begin
            for (int unsigned j = 0; j < 16; j++) begin
              if (byte_q == 5'(j)) rdat_d[127-8*j -: 8] = sh_q;
            end
            if (rd_ack_drive) begin
              state_d = RD_BYTE;
              byte_d  = byte_q + 5'd1;
              bit_d   = '0;
            end else begin
              state_d = STOP;
            end
          end
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // START/STOP/RSTART shape SDA edges while SCL is high; data bits only move SDA in Q0.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      IDLE: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
      START: begin
        scl_oe = (qtr_q == 2'd3);
        sda_oe = qtr_q[1];
      end
      STOP: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = !qtr_q[1];
      end
      RSTART: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = qtr_q[1];
      end
      default: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        if ((state_q == ADDR) || (state_q == WR_BYTE)) sda_oe = !sh_q[7];
        else if (state_q == RD_ACK)                    sda_oe = rd_ack_drive;
        else                                           sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      n_q     <= '0;
      m_q     <= '0;
      rd_q    <= 1'b0;
      rw_q    <= 1'b0;
      smp_q   <= 1'b0;
      sh_q    <= '0;
      wbuf_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      n_q     <= n_d;
      m_q     <= m_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      smp_q   <= smp_d;
      sh_q    <= sh_d;
      wbuf_q  <= wbuf_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = err_q;
  assign rd_data = rdat_q;

endmodule

// File: tb/tb_mpu_i2c_engine.sv
// Directed bench for mpu_i2c_engine: an I2C slave model on the open-drain bus
// logs START/STOP, received bytes and master ACK/NACK, and serves read bytes.
module tb_mpu_i2c_engine;

  localparam int EV_START = 256;
  localparam int EV_STOP  = 257;
  localparam int EV_MACK  = 258;
  localparam int EV_MNACK = 259;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_start;
  logic         rd_now;
  logic [15:0]  n_in;
  logic [15:0]  m_in;
  logic [127:0] data_in;
  logic         sda_i;
  logic         scl_oe;
  logic         sda_oe;
  logic         busy;
  logic         done;
  logic         ack_err;
  logic [127:0] rd_data;

  logic         slv_pull;
  logic         slv_reset_req;
  logic         nack_addr;
  logic [7:0]   rd_bytes [16];
  int           trace[$];
  int           exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign sda_i = ~(sda_oe | slv_pull);

  mpu_i2c_engine #(
    .CLK_DIV  (2),
    .DEV_ADDR (7'h68)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_start    (en_start),
    .rd_now      (rd_now),
    .n           (n_in),
    .m           (m_in),
    .data_packed (data_in),
    .sda_i       (sda_i),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .rd_data     (rd_data)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Slave: sees the bus at negedge, changes its SDA pull only while SCL is low.
  initial begin : slave
    logic       scl, sda, scl_p, sda_p, rd_mode, rd_pend, addr_ph, mack;
    logic [7:0] sh, tx;
    int         bitcnt, rd_idx;
    slv_pull = 1'b0;
    scl_p = 1'b1; sda_p = 1'b1; rd_mode = 1'b0; rd_pend = 1'b0; addr_ph = 1'b0;
    mack = 1'b1; sh = '0; tx = '0; bitcnt = 0; rd_idx = 0;
    forever begin
      @(negedge clk);
      scl = ~scl_oe;
      sda = sda_i;
      if (slv_reset_req) begin
        slv_pull = 1'b0; bitcnt = 0; rd_mode = 1'b0; rd_pend = 1'b0; addr_ph = 1'b0;
        scl = 1'b1; sda = 1'b1;
      end else if (scl && scl_p && sda_p && !sda) begin
        trace.push_back(EV_START);
        bitcnt = 0; addr_ph = 1'b1; rd_mode = 1'b0; rd_pend = 1'b0;
      end else if (scl && scl_p && !sda_p && sda) begin
        trace.push_back(EV_STOP);
        bitcnt = 0; addr_ph = 1'b0; rd_mode = 1'b0; rd_pend = 1'b0;
      end else if (scl && !scl_p) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], sda};
          bitcnt++;
        end else if (bitcnt == 8) begin
          if (rd_mode) begin
            mack = sda;
            trace.push_back(sda ? EV_MNACK : EV_MACK);
          end
          bitcnt = 9;
        end
      end else if (!scl && scl_p) begin
        if (bitcnt == 8) begin
          if (rd_mode) begin
            slv_pull = 1'b0;
          end else begin
            trace.push_back(int'(sh));
            if (addr_ph) begin
              slv_pull = !nack_addr;
              rd_pend  = sh[0] && !nack_addr;
              addr_ph  = 1'b0;
            end else begin
              slv_pull = 1'b1;
            end
          end
        end else if (bitcnt == 9) begin
          slv_pull = 1'b0;
          bitcnt   = 0;
          if (rd_pend) begin
            rd_mode = 1'b1; rd_pend = 1'b0; rd_idx = 0; mack = 1'b0;
          end
          if (rd_mode && !mack && rd_idx < 16) begin
            tx = rd_bytes[rd_idx];
            rd_idx++;
            slv_pull = !tx[7];
          end
        end else if (rd_mode && bitcnt >= 1 && bitcnt <= 7) begin
          slv_pull = !tx[7-bitcnt];
        end
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  task automatic check_trace(input string tag, input int base);
    check_eq({tag, "_trace_len"}, 128'(trace.size() - base), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < trace.size())
        check_eq($sformatf("%s_ev%0d", tag, i), 128'(trace[base+i]), 128'(exp_q[i]));
    end
  endtask

  task automatic run_cmd(input logic rd, input logic [15:0] nn, input logic [15:0] mm,
                         input logic [127:0] d, input int exp_cyc, input int inject_at,
                         input string tag);
    int cyc, guard, extra_done, extra_busy;
    @(negedge clk);
    rd_now = rd; n_in = nn; m_in = mm; data_in = d; en_start = 1'b1;
    @(negedge clk);
    en_start = 1'b0;
    cyc = 0; guard = 0;
    while (!done && guard < 5000) begin
      if (busy) cyc++;
      en_start = (cyc == inject_at);
      guard++;
      @(negedge clk);
    end
    en_start = 1'b0;
    check_eq({tag, "_done"}, 128'(done), 128'(1));
    check_eq({tag, "_busy_at_done"}, 128'(busy), 128'(0));
    check_eq({tag, "_busy_cycles"}, 128'(cyc), 128'(exp_cyc));
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    check_eq({tag, "_extra_done"}, 128'(extra_done), 128'(0));
    check_eq({tag, "_extra_busy"}, 128'(extra_busy), 128'(0));
  endtask

  task automatic exp_write_t1();
    exp_q.delete();
    exp_q.push_back(EV_START); exp_q.push_back('hD0); exp_q.push_back('h6B);
    exp_q.push_back('h00);     exp_q.push_back(EV_STOP);
  endtask

  initial begin : main
    int           base;
    logic [127:0] exp_rd;
    logic [127:0] t1_data;
    rst_n = 1'b0; en_start = 1'b0; rd_now = 1'b0; n_in = '0; m_in = '0; data_in = '0;
    nack_addr = 1'b0; slv_reset_req = 1'b0;
    for (int j = 0; j < 16; j++) rd_bytes[j] = 8'(j + 1);
    t1_data = {16'h6B00, 112'h0};

    repeat (3) @(negedge clk);
    check_eq("rst_scl_oe", 128'(scl_oe), 128'(0));
    check_eq("rst_sda_oe", 128'(sda_oe), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_ack_err", 128'(ack_err), 128'(0));
    check_eq("rst_rd_data", rd_data, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: write 6B 00, 29 bit-times of 8 clocks
    base = trace.size();
    run_cmd(1'b0, 16'd2, 16'd1, t1_data, 232, -1, "t1");
    exp_write_t1();
    check_trace("t1", base);
    check_eq("t1_ack_err", 128'(ack_err), 128'(0));

    // T2: write 3B, repeated START, read 14 bytes
    base = trace.size();
    run_cmd(1'b1, 16'd1, 16'd14, {8'h3B, 120'h0}, 1248, -1, "t2");
    exp_q.delete();
    exp_q.push_back(EV_START); exp_q.push_back('hD0); exp_q.push_back('h3B);
    exp_q.push_back(EV_START); exp_q.push_back('hD1);
    for (int j = 0; j < 13; j++) exp_q.push_back(EV_MACK);
    exp_q.push_back(EV_MNACK); exp_q.push_back(EV_STOP);
    check_trace("t2", base);
    exp_rd = '0;
    for (int j = 0; j < 14; j++) exp_rd[127-8*j -: 8] = 8'(j + 1);
    check_eq("t2_rd_data", rd_data, exp_rd);
    check_eq("t2_ack_err", 128'(ack_err), 128'(0));

    // T3: address NACK
    nack_addr = 1'b1;
    base = trace.size();
    run_cmd(1'b0, 16'd2, 16'd1, t1_data, 88, -1, "t3");
    exp_q.delete();
    exp_q.push_back(EV_START); exp_q.push_back('hD0); exp_q.push_back(EV_STOP);
    check_trace("t3", base);
    check_eq("t3_ack_err", 128'(ack_err), 128'(1));
    check_eq("t3_rd_data_cleared", rd_data, '0);
    nack_addr = 1'b0;

    // T4: en_start while busy is ignored; accept clears the previous ack_err
    base = trace.size();
    run_cmd(1'b0, 16'd2, 16'd1, t1_data, 232, 60, "t4");
    exp_write_t1();
    check_trace("t4", base);
    check_eq("t4_ack_err", 128'(ack_err), 128'(0));

    // T5: async reset mid-byte
    @(negedge clk);
    rd_now = 1'b0; n_in = 16'd2; m_in = 16'd1; data_in = t1_data; en_start = 1'b1;
    @(negedge clk);
    en_start = 1'b0;
    repeat (41) @(negedge clk);
    check_eq("t5_busy_before", 128'(busy), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_scl_oe", 128'(scl_oe), 128'(0));
    check_eq("t5_sda_oe", 128'(sda_oe), 128'(0));
    check_eq("t5_busy", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    slv_reset_req = 1'b1;
    @(negedge clk);
    slv_reset_req = 1'b0;
    repeat (3) @(negedge clk);
    base = trace.size();
    run_cmd(1'b0, 16'd2, 16'd1, t1_data, 232, -1, "t5");
    exp_write_t1();
    check_trace("t5", base);
    check_eq("t5_ack_err", 128'(ack_err), 128'(0));

    // T6: n=0 read-only, one byte
    rd_bytes[0] = 8'hA5;
    base = trace.size();
    run_cmd(1'b1, 16'd0, 16'd1, '0, 160, -1, "t6");
    exp_q.delete();
    exp_q.push_back(EV_START); exp_q.push_back('hD1);
    exp_q.push_back(EV_MNACK); exp_q.push_back(EV_STOP);
    check_trace("t6", base);
    check_eq("t6_rd_data", rd_data, {8'hA5, 120'h0});

    // T7: m=0 clamps to a single read byte
    rd_bytes[0] = 8'h5C;
    base = trace.size();
    run_cmd(1'b1, 16'd0, 16'd0, '0, 160, -1, "t7");
    check_trace("t7", base);
    check_eq("t7_rd_data", rd_data, {8'h5C, 120'h0});

    // T8: address-only probe
    base = trace.size();
    run_cmd(1'b0, 16'd0, 16'd1, '0, 88, -1, "t8");
    exp_q.delete();
    exp_q.push_back(EV_START); exp_q.push_back('hD0); exp_q.push_back(EV_STOP);
    check_trace("t8", base);
    check_eq("t8_ack_err", 128'(ack_err), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
